// File: rtl/fixed_pkg.sv
// Shared fixed-point helpers for the add/mult/convert blocks: quantisation and
// overflow mode codes plus full-precision width arithmetic.
package fixed_pkg;

  localparam int QUANT_TRUNC = 0;
  localparam int QUANT_ROUND = 1;
  localparam int OVF_WRAP    = 0;
  localparam int OVF_SAT     = 1;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // One extra integer bit so a +/- b can never overflow.
  function automatic int full_int_bits(input int n_a, input int bp_a,
                                       input int n_b, input int bp_b);
    return max2(n_a - bp_a, n_b - bp_b) + 1;
  endfunction

  function automatic int full_frac_bits(input int bp_a, input int bp_b);
    return max2(bp_a, bp_b);
  endfunction

endpackage

// File: rtl/fixed_quant.sv
// Registered requantiser: S2 moves the binary point (truncate or round half up),
// S3 range-checks into the output format (wrap or saturate). Both stages hold on ~en_i.
module fixed_quant
  import fixed_pkg::*;
#(
  parameter int N_IN     = 6,
  parameter int BP_IN    = 3,
  parameter int N_OUT    = 6,
  parameter int BP_OUT   = 3,
  parameter int QUANT    = 0,
  parameter int OVERFLOW = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic signed [N_IN-1:0]  din_i,
  output logic signed [N_OUT-1:0] sum_o,
  output logic                    ovf_o
);

  localparam int SHL     = (BP_OUT >= BP_IN) ? BP_OUT - BP_IN : 0;
  localparam int SHR     = (BP_OUT >= BP_IN) ? 0 : BP_IN - BP_OUT;
  localparam int EW      = N_IN + SHL + 1;
  localparam int QW      = EW - SHR;
  localparam int CW      = max2(QW, N_OUT) + 1;
  localparam int RND_POS = (SHR > 0) ? SHR - 1 : 0;

  // The extra top bit of ext is the guard that keeps a rounding carry.
  function automatic logic signed [QW-1:0] quantise(input logic signed [N_IN-1:0] x);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] half;
    ext  = {{(SHL + 1){x[N_IN-1]}}, x};
    ext  = ext <<< SHL;
    half = '0;
    if (QUANT == QUANT_ROUND && SHR > 0) half[RND_POS] = 1'b1;
    ext  = ext + half;
    return ext[EW-1:SHR];
  endfunction

  // Returns {ovf, result}.
  function automatic logic [N_OUT:0] range_fit(input logic signed [QW-1:0] q);
    logic signed [CW-1:0] qx;
    logic signed [CW-1:0] maxv;
    logic signed [CW-1:0] minv;
    logic                 ovf;
    logic [N_OUT-1:0]     res;
    qx   = {{(CW - QW){q[QW-1]}}, q};
    maxv = '0;
    for (int i = 0; i < N_OUT - 1; i++) maxv[i] = 1'b1;
    minv = ~maxv;
    ovf  = (qx > maxv) || (qx < minv);
    res  = qx[N_OUT-1:0];
    if (OVERFLOW == OVF_SAT && ovf) res = qx[CW-1] ? minv[N_OUT-1:0] : maxv[N_OUT-1:0];
    return {ovf, res};
  endfunction

  logic signed [QW-1:0] q_p2_d, q_p2_q;
  logic [N_OUT:0]       fit_p3_d;
  logic [N_OUT-1:0]     sum_q;
  logic                 ovf_q;

  // S2: quantise to BP_OUT
  always_comb q_p2_d = quantise(din_i);

  always_ff @(posedge clk_i) begin
    if (en_i) q_p2_q <= q_p2_d;
  end

  // S3: range check and overflow handling
  always_comb fit_p3_d = range_fit(q_p2_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= fit_p3_d[N_OUT-1:0];
      ovf_q <= fit_p3_d[N_OUT];
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/addsub_pipe.sv
// Three-stage signed fixed-point add/subtract with valid/ready handshake.
// S1 aligns and adds at full precision here; S2/S3 live in fixed_quant.
module addsub_pipe
  import fixed_pkg::*;
#(
  parameter int N_BITS_A   = 3,
  parameter int BIN_PT_A   = 1,
  parameter int N_BITS_B   = 4,
  parameter int BIN_PT_B   = 3,
  parameter int N_BITS_OUT = 6,
  parameter int BIN_PT_OUT = 3,
  parameter int QUANT      = 0,
  parameter int OVERFLOW   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [N_BITS_A-1:0]   a,
  input  logic signed [N_BITS_B-1:0]   b,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [N_BITS_OUT-1:0] sum,
  output logic                         ovf
);

  localparam int BP_F = full_frac_bits(BIN_PT_A, BIN_PT_B);
  localparam int I_F  = full_int_bits(N_BITS_A, BIN_PT_A, N_BITS_B, BIN_PT_B);
  localparam int N_F  = I_F + BP_F;
  localparam int SHA  = BP_F - BIN_PT_A;
  localparam int SHB  = BP_F - BIN_PT_B;

  if (N_BITS_A < 1 || N_BITS_B < 1 || N_BITS_OUT < 1 ||
      BIN_PT_A < 0 || BIN_PT_A > N_BITS_A ||
      BIN_PT_B < 0 || BIN_PT_B > N_BITS_B ||
      BIN_PT_OUT < 0 || BIN_PT_OUT > N_BITS_OUT) begin : g_bad_width
    $error("addsub_pipe: illegal width or binary point parameters");
  end
  if (QUANT != QUANT_TRUNC && QUANT != QUANT_ROUND) begin : g_bad_quant
    $error("addsub_pipe: QUANT must be 0 or 1");
  end
  if (OVERFLOW != OVF_WRAP && OVERFLOW != OVF_SAT) begin : g_bad_ovf
    $error("addsub_pipe: OVERFLOW must be 0 or 1");
  end

  logic                  advance;
  logic signed [N_F-1:0] a_al, b_al;
  logic signed [N_F-1:0] acc_p1_d, acc_p1_q;
  logic                  vld_p1_d, vld_p1_q;
  logic                  vld_p2_d, vld_p2_q;
  logic                  vld_p3_d, vld_p3_q;

  // Global stall: every stage, bubbles included, moves only when the output slot frees.
  assign advance  = out_ready | ~vld_p3_q;
  assign in_ready = advance;

  // S1: align binary points and add/subtract at full precision
  always_comb begin
    a_al     = {{(N_F - N_BITS_A){a[N_BITS_A-1]}}, a};
    a_al     = a_al <<< SHA;
    b_al     = {{(N_F - N_BITS_B){b[N_BITS_B-1]}}, b};
    b_al     = b_al <<< SHB;
    acc_p1_d = sub ? (a_al - b_al) : (a_al + b_al);
  end

  always_ff @(posedge clk) begin
    if (advance) acc_p1_q <= acc_p1_d;
  end

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    vld_p3_d = vld_p3_q;
    if (advance) begin
      vld_p1_d = in_valid;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  fixed_quant #(
    .N_IN    (N_F),
    .BP_IN   (BP_F),
    .N_OUT   (N_BITS_OUT),
    .BP_OUT  (BIN_PT_OUT),
    .QUANT   (QUANT),
    .OVERFLOW(OVERFLOW)
  ) u_quant (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (advance),
    .din_i (acc_p1_q),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  assign out_valid = vld_p3_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: default format plus narrow-output wrap/saturate
// and truncate/round variants, all driven from one shared input stream.
module tb_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, sub, out_ready;
  logic [2:0] a;
  logic [3:0] b;

  logic ir_m, ov_m, of_m; logic [5:0] s_m;
  logic ir_s, ov_s, of_s; logic [3:0] s_s;
  logic ir_w, ov_w, of_w; logic [3:0] s_w;
  logic ir_t, ov_t, of_t; logic [3:0] s_t;
  logic ir_r, ov_r, of_r; logic [3:0] s_r;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] a;  logic [3:0] b;  logic sub;
    logic [5:0] m;
    logic [3:0] s;  logic so;
    logic [3:0] w;  logic wo;
    logic [3:0] t;  logic [3:0] r;
  } vec_t;
  vec_t tbl [8];

  addsub_pipe dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_m), .a(a), .b(b), .sub(sub),
    .out_valid(ov_m), .out_ready(out_ready), .sum(s_m), .ovf(of_m));

  addsub_pipe #(.N_BITS_OUT(4), .BIN_PT_OUT(3), .OVERFLOW(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s), .a(a), .b(b), .sub(sub),
    .out_valid(ov_s), .out_ready(out_ready), .sum(s_s), .ovf(of_s));

  addsub_pipe #(.N_BITS_OUT(4), .BIN_PT_OUT(3), .OVERFLOW(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w), .a(a), .b(b), .sub(sub),
    .out_valid(ov_w), .out_ready(out_ready), .sum(s_w), .ovf(of_w));

  addsub_pipe #(.N_BITS_OUT(4), .BIN_PT_OUT(1), .QUANT(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_t), .a(a), .b(b), .sub(sub),
    .out_valid(ov_t), .out_ready(out_ready), .sum(s_t), .ovf(of_t));

  addsub_pipe #(.N_BITS_OUT(4), .BIN_PT_OUT(1), .QUANT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_r), .a(a), .b(b), .sub(sub),
    .out_valid(ov_r), .out_ready(out_ready), .sum(s_r), .ovf(of_r));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    a   = tbl[i].a;
    b   = tbl[i].b;
    sub = tbl[i].sub;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov_m); end
    n_tests++; if (s_m !== 6'd0) begin n_fail++; $display("FAIL reset_sum got=%b exp=000000", s_m); end
    n_tests++; if (of_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", of_m); end
    n_tests++; if (ir_m !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ir_m); end
    n_tests++; if (s_s !== 4'd0 || of_s !== 1'b0) begin
      n_fail++; $display("FAIL reset_sat got=%b/%b exp=0000/0", s_s, of_s);
    end
  endtask

  task automatic test_latency();
    drive(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL lat_c1_valid got=%b exp=0", ov_m); end
    tick();
    n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL lat_c2_valid got=%b exp=0", ov_m); end
    tick();
    n_tests++; if (ov_m !== 1'b1) begin n_fail++; $display("FAIL lat_c3_valid got=%b exp=1", ov_m); end
    n_tests++; if (s_m !== tbl[0].m) begin n_fail++; $display("FAIL lat_c3_sum got=%b exp=%b", s_m, tbl[0].m); end
    tick();
    n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL lat_c4_valid got=%b exp=0", ov_m); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int rcv  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (sent < 8);
      if (sent < 8) drive(sent);
      #1;
      if (ov_m) begin
        if (rcv >= 8) begin
          n_tests++; n_fail++; $display("FAIL stream_extra got=valid exp=idle");
        end else begin
          n_tests++; if (s_m !== tbl[rcv].m || of_m !== 1'b0) begin
            n_fail++; $display("FAIL stream_main[%0d] got=%b/%b exp=%b/0", rcv, s_m, of_m, tbl[rcv].m);
          end
          n_tests++; if (s_s !== tbl[rcv].s || of_s !== tbl[rcv].so) begin
            n_fail++; $display("FAIL stream_sat[%0d] got=%b/%b exp=%b/%b", rcv, s_s, of_s, tbl[rcv].s, tbl[rcv].so);
          end
          n_tests++; if (s_w !== tbl[rcv].w || of_w !== tbl[rcv].wo) begin
            n_fail++; $display("FAIL stream_wrap[%0d] got=%b/%b exp=%b/%b", rcv, s_w, of_w, tbl[rcv].w, tbl[rcv].wo);
          end
          n_tests++; if (s_t !== tbl[rcv].t || of_t !== 1'b0) begin
            n_fail++; $display("FAIL stream_trunc[%0d] got=%b/%b exp=%b/0", rcv, s_t, of_t, tbl[rcv].t);
          end
          n_tests++; if (s_r !== tbl[rcv].r || of_r !== 1'b0) begin
            n_fail++; $display("FAIL stream_round[%0d] got=%b/%b exp=%b/0", rcv, s_r, of_r, tbl[rcv].r);
          end
          rcv++;
        end
      end
      if (in_valid && ir_m) sent++;
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (rcv !== 8) begin n_fail++; $display("FAIL stream_count got=%0d exp=8", rcv); end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         rcv  = 0;
    logic       stalled_prev = 1'b0;
    logic [5:0] held = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c < 12);
      in_valid  = (sent < 6);
      if (sent < 6) drive(sent);
      #1;
      if (stalled_prev) begin
        n_tests++; if (ov_m !== 1'b1 || s_m !== held) begin
          n_fail++; $display("FAIL bp_hold c=%0d got=%b/%b exp=1/%b", c, ov_m, s_m, held);
        end
      end
      if (ov_m && !out_ready) begin
        n_tests++; if (ir_m !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, ir_m); end
      end
      if (ov_m && out_ready) begin
        if (rcv >= 6) begin
          n_tests++; n_fail++; $display("FAIL bp_duplicate got=valid exp=idle");
        end else begin
          n_tests++; if (s_m !== tbl[rcv].m) begin
            n_fail++; $display("FAIL bp_order[%0d] got=%b exp=%b", rcv, s_m, tbl[rcv].m);
          end
          rcv++;
        end
      end
      stalled_prev = ov_m && !out_ready;
      held         = s_m;
      if (in_valid && ir_m) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (rcv !== 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", rcv); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (ov_m !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got=%b exp=1", ov_m); end
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", ov_m); end
    n_tests++; if (ir_m !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b exp=1", ir_m); end
    n_tests++; if (s_m !== 6'd0) begin n_fail++; $display("FAIL mid_sum got=%b exp=000000", s_m); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++; if (ov_m !== 1'b0) begin n_fail++; $display("FAIL mid_ghost c=%0d got=%b exp=0", c, ov_m); end
    end
  endtask

  initial begin
    tbl[0] = '{3'b111, 4'b0001, 1'b0, 6'b111101, 4'b1101, 1'b0, 4'b1101, 1'b0, 4'b1111, 4'b1111};
    tbl[1] = '{3'b110, 4'b1100, 1'b0, 6'b110100, 4'b1000, 1'b1, 4'b0100, 1'b1, 4'b1101, 4'b1101};
    tbl[2] = '{3'b011, 4'b1110, 1'b1, 6'b001110, 4'b0111, 1'b1, 4'b1110, 1'b1, 4'b0011, 4'b0100};
    tbl[3] = '{3'b011, 4'b0001, 1'b0, 6'b001101, 4'b0111, 1'b1, 4'b1101, 1'b1, 4'b0011, 4'b0011};
    tbl[4] = '{3'b000, 4'b0011, 1'b0, 6'b000011, 4'b0011, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001};
    tbl[5] = '{3'b000, 4'b0010, 1'b0, 6'b000010, 4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0001};
    tbl[6] = '{3'b011, 4'b1000, 1'b1, 6'b010100, 4'b0111, 1'b1, 4'b0100, 1'b1, 4'b0101, 4'b0101};
    tbl[7] = '{3'b100, 4'b0111, 1'b1, 6'b101001, 4'b1000, 1'b1, 4'b1001, 1'b1, 4'b1010, 4'b1010};

    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_reset_midstream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
